// File: rtl/amp_average.sv
// Lock-in amplitude averager: settle, accumulate 2**LOG2_N samples,
// present the truncated mean on a valid/ready output.
module amp_average #(
  parameter int DW         = 24,
  parameter int LOG2_N     = 8,
  parameter int SETTLE_CNT = 64,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic          amp_valid,
  input  logic [DW-1:0] amp_data,
  output logic          avg_tvalid,
  input  logic          avg_tready,
  output logic [DW-1:0] avg_tdata,
  output logic          busy,
  output logic          dropped
);

  localparam int AW = DW + LOG2_N;
  localparam int SW = (SETTLE_CNT > 1) ? $clog2(SETTLE_CNT) : 1;
  localparam logic [SW-1:0] S_LAST =
    SW'((SETTLE_CNT > 0) ? SETTLE_CNT - 1 : 0);
  localparam logic [LOG2_N-1:0] C_LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM,
    HOLD
  } state_t;

  state_t            state;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     sum;
  logic [LOG2_N-1:0] cnt;
  logic [SW-1:0]     scnt;

  // Wide enough that 2**LOG2_N full-scale samples cannot overflow
  assign sum = acc + {{LOG2_N{1'b0}}, amp_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      avg_tvalid <= 1'b0;
      avg_tdata  <= '0;
      busy       <= 1'b0;
      dropped    <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      scnt       <= '0;
    end else if (stop) begin
      state      <= IDLE;
      avg_tvalid <= 1'b0;
      busy       <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      scnt       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= (SETTLE_CNT > 0) ? SETTLE : ACCUM;
            busy    <= 1'b1;
            dropped <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            scnt    <= '0;
          end
        end
        SETTLE: begin
          if (amp_valid) begin
            if (scnt == S_LAST) begin
              state <= ACCUM;
              scnt  <= '0;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        ACCUM: begin
          if (amp_valid) begin
            if (cnt == C_LAST) begin
              state      <= HOLD;
              avg_tvalid <= 1'b1;
              avg_tdata  <= sum[AW-1:LOG2_N];
              acc        <= '0;
              cnt        <= '0;
            end else begin
              acc <= sum;
              cnt <= cnt + LOG2_N'(1);
            end
          end
        end
        HOLD: begin
          if (amp_valid) dropped <= 1'b1;
          if (avg_tready) begin
            avg_tvalid <= 1'b0;
            state      <= CONTINUOUS ? ACCUM : IDLE;
            busy       <= CONTINUOUS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amp_average.sv
// Bench for amp_average: reference model on instance a, directed
// literal checks on a and on three other parameterisations.
module tb_amp_average;

  localparam int A_SETTLE = 2;
  localparam int A_N      = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        a_start, a_stop, a_valid, a_ready;
  logic [23:0] a_data, a_tdata;
  logic        a_tvalid, a_busy, a_drop;
  logic        b_start, b_stop, b_valid, b_ready;
  logic [23:0] b_data, b_tdata;
  logic        b_tvalid, b_busy, b_drop;
  logic        c_start, c_stop, c_valid, c_ready;
  logic [23:0] c_data, c_tdata;
  logic        c_tvalid, c_busy, c_drop;
  logic        d_start, d_stop, d_valid, d_ready;
  logic [23:0] d_data, d_tdata;
  logic        d_tvalid, d_busy, d_drop;

  amp_average #(.DW(24), .LOG2_N(4), .SETTLE_CNT(A_SETTLE),
    .CONTINUOUS(1'b0)) u_a (
    .clk(clk), .rstn(rstn), .start(a_start), .stop(a_stop),
    .amp_valid(a_valid), .amp_data(a_data),
    .avg_tvalid(a_tvalid), .avg_tready(a_ready),
    .avg_tdata(a_tdata), .busy(a_busy), .dropped(a_drop));

  amp_average #(.DW(24), .LOG2_N(4), .SETTLE_CNT(0),
    .CONTINUOUS(1'b0)) u_b (
    .clk(clk), .rstn(rstn), .start(b_start), .stop(b_stop),
    .amp_valid(b_valid), .amp_data(b_data),
    .avg_tvalid(b_tvalid), .avg_tready(b_ready),
    .avg_tdata(b_tdata), .busy(b_busy), .dropped(b_drop));

  amp_average #(.DW(24), .LOG2_N(16), .SETTLE_CNT(0),
    .CONTINUOUS(1'b0)) u_c (
    .clk(clk), .rstn(rstn), .start(c_start), .stop(c_stop),
    .amp_valid(c_valid), .amp_data(c_data),
    .avg_tvalid(c_tvalid), .avg_tready(c_ready),
    .avg_tdata(c_tdata), .busy(c_busy), .dropped(c_drop));

  amp_average #(.DW(24), .LOG2_N(2), .SETTLE_CNT(0),
    .CONTINUOUS(1'b1)) u_d (
    .clk(clk), .rstn(rstn), .start(d_start), .stop(d_stop),
    .amp_valid(d_valid), .amp_data(d_data),
    .avg_tvalid(d_tvalid), .avg_tready(d_ready),
    .avg_tdata(d_tdata), .busy(d_busy), .dropped(d_drop));

  int n_tests = 0;
  int n_fail  = 0;

  // Abstract model of instance a
  bit          m_busy, m_valid, m_drop;
  int          m_skip, m_n;
  longint      m_sum;
  logic [23:0] m_data;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rs, input logic s,
    input logic p, input logic v, input logic [23:0] d,
    input logic r);
    if (!rs) begin
      m_busy = 0; m_valid = 0; m_drop = 0;
      m_skip = 0; m_n = 0; m_sum = 0; m_data = '0;
    end else if (p) begin
      m_busy = 0; m_valid = 0;
      m_skip = 0; m_n = 0; m_sum = 0;
    end else if (!m_busy) begin
      if (s) begin
        m_busy = 1; m_drop = 0;
        m_skip = A_SETTLE; m_n = 0; m_sum = 0;
      end
    end else if (m_valid) begin
      if (v) m_drop = 1;
      if (r) begin
        m_valid = 0;
        m_busy  = 0;
      end
    end else if (v) begin
      if (m_skip > 0) begin
        m_skip--;
      end else begin
        m_sum += longint'(d);
        m_n++;
        if (m_n == A_N) begin
          m_valid = 1;
          m_data  = 24'(m_sum / A_N);
          m_sum   = 0;
          m_n     = 0;
        end
      end
    end
  endtask

  // One clock: sample a's inputs at the edge, advance model, compare
  task automatic tick();
    logic rs, s, p, v, r;
    logic [23:0] d;
    @(posedge clk);
    rs = rstn; s = a_start; p = a_stop;
    v = a_valid; d = a_data; r = a_ready;
    #1;
    model_step(rs, s, p, v, d, r);
    check("m_tvalid", a_tvalid, m_valid);
    check("m_tdata", a_tdata, m_data);
    check("m_busy", a_busy, m_busy);
    check("m_dropped", a_drop, m_drop);
  endtask

  task automatic a_sample(input logic [23:0] val);
    a_valid = 1'b1;
    a_data  = val;
    tick();
  endtask

  initial begin
    int k;
    bit last;
    rstn = 1'b0;
    {a_start, a_stop, a_valid, a_ready, a_data} = '0;
    {b_start, b_stop, b_valid, b_ready, b_data} = '0;
    {c_start, c_stop, c_valid, c_ready, c_data} = '0;
    {d_start, d_stop, d_valid, d_ready, d_data} = '0;
    tick();
    tick();
    check("rst_a_busy", a_busy, 0);
    check("rst_b_tvalid", b_tvalid, 0);
    check("rst_c_tdata", c_tdata, 0);
    check("rst_d_dropped", d_drop, 0);
    rstn = 1'b1;
    tick();

    // T1
    a_ready = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (2) a_sample(24'hFFFFFF);
    for (int i = 0; i < 16; i++) begin
      a_sample(24'd100);
      if (i < 15) check("t1_early", a_tvalid, 0);
    end
    check("t1_tvalid", a_tvalid, 1);
    check("t1_tdata", a_tdata, 100);
    a_valid = 1'b0;
    tick();
    check("t1_oneshot", a_tvalid, 0);
    check("t1_idle", a_busy, 0);

    // T2
    b_ready = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 600 && k < 16; cyc++) begin
      last = 0;
      if ($urandom_range(0, 9) < 3) begin
        b_valid = 1'b1;
        b_data  = 24'(k);
        k++;
        last = (k == 16);
      end else begin
        b_valid = 1'b0;
      end
      tick();
      check("t2_timing", b_tvalid, last);
    end
    check("t2_budget", k, 16);
    check("t2_tdata", b_tdata, 7);
    b_valid = 1'b0;
    tick();
    check("t2_drop", b_tvalid, 0);
    check("t2_idle", b_busy, 0);

    // T3
    c_ready = 1'b1;
    c_start = 1'b1;
    tick();
    c_start = 1'b0;
    c_valid = 1'b1;
    c_data  = 24'hFFFFFF;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (i == 65534) check("t3_early", c_tvalid, 0);
    end
    check("t3_tvalid", c_tvalid, 1);
    check("t3_tdata", c_tdata, 32'hFFFFFF);
    c_valid = 1'b0;
    tick();

    // T4
    d_ready = 1'b0;
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    repeat (4) begin
      d_valid = 1'b1;
      d_data  = 24'd40;
      tick();
    end
    check("t4_tvalid", d_tvalid, 1);
    check("t4_tdata", d_tdata, 40);
    d_data = 24'd999;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stall_v", d_tvalid, 1);
      check("t4_stall_d", d_tdata, 40);
    end
    check("t4_dropped", d_drop, 1);
    d_ready = 1'b1;
    tick();
    check("t4_hs", d_tvalid, 0);
    check("t4_rearm", d_busy, 1);
    for (int i = 1; i <= 4; i++) begin
      d_data = 24'(4 * i);
      tick();
    end
    check("t4_tvalid2", d_tvalid, 1);
    check("t4_tdata2", d_tdata, 10);
    d_valid = 1'b0;
    tick();
    check("t4_hs2", d_tvalid, 0);
    check("t4_cont", d_busy, 1);

    // T5: stop mid-accumulation
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (2) a_sample(24'd5);
    repeat (7) a_sample(24'd50);
    a_valid = 1'b0;
    a_stop  = 1'b1;
    tick();
    a_stop = 1'b0;
    check("t5_stop_idle", a_busy, 0);
    check("t5_stop_nov", a_tvalid, 0);
    check("t5_keep_data", a_tdata, 100);
    repeat (3) a_sample(24'd7);
    // start while busy is ignored
    a_valid = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (2) a_sample(24'd5);
    repeat (5) a_sample(24'd1000);
    a_start = 1'b1;
    a_sample(24'd0);
    a_start = 1'b0;
    repeat (10) a_sample(24'd0);
    check("t5_guard_v", a_tvalid, 1);
    check("t5_guard_d", a_tdata, 312);
    a_ready = 1'b0;
    a_sample(24'd9);
    check("t5_dropped", a_drop, 1);
    a_ready = 1'b1;
    a_valid = 1'b0;
    tick();
    a_start = 1'b1;
    a_stop  = 1'b1;
    tick();
    {a_start, a_stop} = 2'b00;
    check("t5_ss_idle", a_busy, 0);
    tick();
    check("t5_ss_idle2", a_busy, 0);
    check("t5_ss_drop", a_drop, 1);

    // T6: asynchronous reset mid-accumulation
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (2) a_sample(24'd5);
    repeat (9) a_sample(24'd77);
    a_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    check("t6_busy", a_busy, 0);
    check("t6_tvalid", a_tvalid, 0);
    check("t6_tdata", a_tdata, 0);
    check("t6_dropped", a_drop, 0);
    tick();
    rstn = 1'b1;
    tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (2) a_sample(24'd3);
    for (int i = 0; i < 16; i++) a_sample(24'(i + 32));
    check("t6_avg_v", a_tvalid, 1);
    check("t6_avg_d", a_tdata, 39);
    a_valid = 1'b0;
    tick();
    check("t6_idle", a_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
